// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several requesters share one UART transmitter.
// One frame is in flight at a time: grant in IDLE, present to the transmitter
// in ISSUE, then wait for its completion pulse (bounded by a timeout) in WAIT_DONE.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_REQ      = 4,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_error,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          parity_per_byte,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_error,
    output logic                          tx_parity_per_byte,
    input  logic                          tx_ready,
    input  logic                          tx_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DONE_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_TERM = CW'(DONE_TIMEOUT - 1);
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [GW-1:0]           last_grant;
    logic [CW-1:0]           done_cnt;
    logic                    win_found;
    logic [GW-1:0]           win_idx;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    win_err;
    logic                    timeout_hit;

    // Search starts just after the last winner, so the previous winner is
    // considered last and cannot win twice while someone else is waiting.
    function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [GW-1:0]      last);
        logic [GW:0] res;
        int          cand;
        res = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!res[GW] && vld[GW'(cand)]) res = {1'b1, GW'(cand)};
        end
        return res;
    endfunction

    // Pick the round-robin winner and select its payload and error flag
    always_comb begin
        {win_found, win_idx} = rr_pick(req_valid, last_grant);
        win_data = '0;
        win_err  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (GW'(k) == win_idx) begin
                win_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
                win_err  = req_error[k];
            end
        end
    end

    // Timeout fires only when no completion pulse arrives in the terminal cycle
    assign timeout_hit = (state == WAIT_DONE) && !tx_done && (done_cnt == CNT_TERM);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake outputs; req_ready is forced low while
    // reset is held so the accept pulse cannot leak out during reset
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_valid  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready = rst_n ? (NUM_REQ'(1) << win_idx) : '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's frame and record the grant at the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant         <= LAST_RST;
            grant_id           <= '0;
            tx_data            <= '0;
            tx_error           <= 1'b0;
            tx_parity_per_byte <= 1'b0;
        end else if (state == IDLE && win_found) begin
            last_grant         <= win_idx;
            grant_id           <= win_idx;
            tx_data            <= win_data;
            tx_error           <= win_err;
            tx_parity_per_byte <= parity_per_byte;
        end
    end

    // Completion timeout counter (held at zero until WAIT_DONE, saturates at
    // the terminal count) and the sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != WAIT_DONE)
                done_cnt <= '0;
            else if (done_cnt != CNT_TERM)
                done_cnt <= done_cnt + 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of full frames plus hand-written corner
// sequences; a monitor pops the scoreboard at each transmitter handshake.
module tb_uart_tx_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_error;
    logic [NR-1:0]     req_ready;
    logic              parity_per_byte;
    logic              tx_valid;
    logic [DW-1:0]     tx_data;
    logic              tx_error;
    logic              tx_parity_per_byte;
    logic              tx_ready;
    logic              tx_done;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DONE_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_error(req_error), .req_ready(req_ready), .parity_per_byte(parity_per_byte),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_error(tx_error),
        .tx_parity_per_byte(tx_parity_per_byte), .tx_ready(tx_ready), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] data;
        logic [3:0]  err;
        logic        par;
        int          rdly;
        int          ddly;
        logic [1:0]  exp_id;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        par;
        logic [1:0]  id;
    } exp_t;

    vec_t tbl[11];
    vec_t follow;
    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   wait_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic e, input logic p, input logic [1:0] id);
        sb_q.push_back('{d, e, p, id});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_tx_valid"},  64'(tx_valid), 64'd0);
        chk({tag, "_tx_data"},   64'(tx_data), 64'd0);
        chk({tag, "_tx_error"},  64'(tx_error), 64'd0);
        chk({tag, "_tx_par"},    64'(tx_parity_per_byte), 64'd0);
        chk({tag, "_grant_id"},  64'(grant_id), 64'd0);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_timeout"},   64'(timeout_err), 64'd0);
    endtask

    // Full frame: accept, ISSUE with optional backpressure, WAIT_DONE, done.
    task automatic run_frame(input vec_t v);
        logic [15:0] hold;
        req_valid = v.valid; req_data = v.data; req_error = v.err;
        parity_per_byte = v.par; tx_ready = 1'b0; tx_done = 1'b0;
        #1;
        chk("frm_idle_busy", 64'(busy), 64'd0);
        chk("frm_req_ready", 64'(req_ready), 64'(4'b0001 << v.exp_id));
        push_exp(16'(v.data >> (32'(v.exp_id) * DW)), v.err[v.exp_id], v.par, v.exp_id);
        @(negedge clk);
        if (v.rdly == 0) tx_ready = 1'b1;
        #1;
        chk("frm_tx_valid", 64'(tx_valid), 64'd1);
        chk("frm_ready_low", 64'(req_ready), 64'd0);
        chk("frm_grant_id", 64'(grant_id), 64'(v.exp_id));
        chk("frm_tx_data", 64'(tx_data), 64'(16'(v.data >> (32'(v.exp_id) * DW))));
        hold = tx_data;
        for (int i = 0; i < v.rdly; i++) begin
            @(negedge clk);
            if (i == v.rdly - 1) tx_ready = 1'b1;
            #1;
            chk("bp_valid", 64'(tx_valid), 64'd1);
            chk("bp_data", 64'(tx_data), 64'(hold));
        end
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        chk("wait_tx_valid", 64'(tx_valid), 64'd0);
        chk("wait_busy", 64'(busy), 64'd1);
        for (int i = 0; i <= v.ddly; i++) begin
            @(negedge clk);
            if (i == v.ddly) tx_done = 1'b1;
            #1;
            chk("wait_busy_hold", 64'(busy), 64'd1);
        end
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("done_idle", 64'(busy), 64'd0);
        chk("done_tx_valid", 64'(tx_valid), 64'd0);
    endtask

    // Scoreboard monitor: each accepted transmitter handshake pops one frame
    always begin
        @(negedge clk);
        #1;
        if (rst_n === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_frame", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_tx_data", 64'(tx_data), 64'(mon_e.data));
                chk("sb_tx_error", 64'(tx_error), 64'(mon_e.err));
                chk("sb_tx_parity", 64'(tx_parity_per_byte), 64'(mon_e.par));
                chk("sb_grant_id", 64'(grant_id), 64'(mon_e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        valid    data                      err      par  rdly ddly id
        tbl[0]  = '{4'b0100, 64'h3333_FCFC_2222_1111, 4'b0000, 1'b0, 0, 3,  2'd2};
        tbl[1]  = '{4'b1111, 64'hA103_A102_A101_A100, 4'b1000, 1'b1, 5, 1,  2'd3};
        tbl[2]  = '{4'b1111, 64'hB203_B202_B201_B200, 4'b0001, 1'b0, 0, 0,  2'd0};
        tbl[3]  = '{4'b1111, 64'hC303_C302_C301_C300, 4'b0100, 1'b1, 1, 2,  2'd1};
        tbl[4]  = '{4'b1111, 64'hD403_D402_D401_D400, 4'b0100, 1'b0, 2, 0,  2'd2};
        tbl[5]  = '{4'b1111, 64'hE503_E502_E501_E500, 4'b0000, 1'b1, 0, 4,  2'd3};
        tbl[6]  = '{4'b1111, 64'hF603_F602_F601_F600, 4'b1110, 1'b0, 0, 1,  2'd0};
        tbl[7]  = '{4'b0011, 64'h0703_0702_0701_0700, 4'b0010, 1'b1, 1, 0,  2'd1};
        tbl[8]  = '{4'b0011, 64'h1803_1802_1801_1800, 4'b0001, 1'b0, 0, 2,  2'd0};
        tbl[9]  = '{4'b1001, 64'h2903_2902_2901_2900, 4'b1000, 1'b1, 3, 0,  2'd3};
        tbl[10] = '{4'b1000, 64'h3A03_3A02_3A01_3A00, 4'b0000, 1'b0, 0, 12, 2'd3};
        follow  = '{4'b0100, 64'h0000_7777_0000_0000, 4'b0000, 1'b1, 1, 2,  2'd2};

        // Reset with requests already pending: nothing may be granted
        rst_n = 1'b0; req_valid = 4'hF; req_data = '1; req_error = 4'hF;
        parity_per_byte = 1'b1; tx_ready = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[e]) run_frame(tbl[e]);

        // tx_done in IDLE and in ISSUE is ignored
        req_valid = 4'b0000; tx_done = 1'b1;
        #1;
        chk("idle_done_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("idle_done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = 4'b0001; req_data = 64'h0000_0000_0000_A5A5; req_error = 4'b0001;
        parity_per_byte = 1'b1;
        #1;
        chk("stray_req_ready", 64'(req_ready), 64'd1);
        push_exp(16'hA5A5, 1'b1, 1'b1, 2'd0);
        @(negedge clk);
        req_valid = 4'b0000; tx_done = 1'b1;
        #1;
        chk("stray_issue_valid", 64'(tx_valid), 64'd1);
        @(negedge clk);
        tx_done = 1'b0; tx_ready = 1'b1;
        #1;
        chk("stray_still_issue", 64'(tx_valid), 64'd1);
        @(negedge clk);
        tx_ready = 1'b0; tx_done = 1'b1;
        #1;
        chk("stray_wait_busy", 64'(busy), 64'd1);
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("stray_done_idle", 64'(busy), 64'd0);

        // tx_done coincides with the terminal count; requester drops valid mid-flight
        @(negedge clk);
        req_valid = 4'b1000; req_data = 64'h0F0F_0000_0000_0000; req_error = 4'b0000;
        parity_per_byte = 1'b1;
        #1;
        chk("coin_req_ready", 64'(req_ready), 64'h8);
        push_exp(16'h0F0F, 1'b0, 1'b1, 2'd3);
        @(negedge clk);
        req_valid = 4'b0000; req_data = '1; tx_ready = 1'b1;
        #1;
        chk("coin_tx_data", 64'(tx_data), 64'h0F0F);
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        chk("coin_wait", 64'(tx_valid), 64'd0);
        repeat (14) @(negedge clk);
        @(negedge clk);
        tx_done = 1'b1;
        #1;
        chk("coin_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("coin_idle", 64'(busy), 64'd0);
        chk("coin_no_timeout", 64'(timeout_err), 64'd0);

        // tx_done never arrives: timeout after 16 WAIT_DONE cycles
        @(negedge clk);
        req_valid = 4'b0010; req_data = 64'h0000_0000_1234_0000; req_error = 4'b0010;
        parity_per_byte = 1'b0;
        #1;
        chk("to_req_ready", 64'(req_ready), 64'h2);
        push_exp(16'h1234, 1'b1, 1'b0, 2'd1);
        @(negedge clk);
        req_valid = 4'b0000; tx_ready = 1'b1;
        #1;
        chk("to_tx_valid", 64'(tx_valid), 64'd1);
        @(negedge clk);
        tx_ready = 1'b0;
        wait_n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!busy) break;
            wait_n++;
            @(negedge clk);
        end
        chk("to_wait_cycles", 64'(wait_n), 64'd16);
        chk("to_flag", 64'(timeout_err), 64'd1);
        chk("to_idle_valid", 64'(tx_valid), 64'd0);
        @(negedge clk);
        run_frame(follow);
        chk("to_sticky", 64'(timeout_err), 64'd1);

        // Reset in the middle of WAIT_DONE drops the frame; requester 0 wins after
        req_valid = 4'hF; req_data = 64'h4444_3333_2222_1111; req_error = 4'b0000;
        parity_per_byte = 1'b1;
        #1;
        chk("mid_req_ready", 64'(req_ready), 64'h8);
        push_exp(16'h4444, 1'b0, 1'b1, 2'd3);
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        chk("mid_tx_valid", 64'(tx_valid), 64'd1);
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        chk("mid_wait_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        push_exp(16'h1111, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        chk("post_rst_valid", 64'(tx_valid), 64'd1);
        chk("post_rst_grant", 64'(grant_id), 64'd0);
        @(negedge clk);
        tx_ready = 1'b0; tx_done = 1'b1; req_valid = 4'b0000;
        #1;
        chk("post_rst_wait", 64'(busy), 64'd1);
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("post_rst_idle", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one UART frame payload.
REQ-002 Parameter NUM_REQ, default 4, number of requesters sharing one transmitter (legal 2..8).
REQ-003 Parameter DONE_TIMEOUT, default 4096, max cycles to wait for tx_done before abort.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester frame request.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  packed payloads, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_error  input  NUM_REQ  per-requester force-parity-error flag.
REQ-009 req_ready  output  NUM_REQ  one-hot accept pulse to the granted requester.
REQ-010 parity_per_byte  input  1  global parity mode, passed through.
REQ-011 tx_valid  output  1  request to transmitter.
REQ-012 tx_data  output  DATA_WIDTH  latched payload to transmitter.
REQ-013 tx_error  output  1  latched error flag to transmitter.
REQ-014 tx_parity_per_byte  output  1  parity mode, latched at grant.
REQ-015 tx_ready  input  1  transmitter accepts when high with tx_valid.
REQ-016 tx_done  input  1  single-cycle frame-complete pulse from transmitter.
REQ-017 grant_id  output  $clog2(NUM_REQ)  index of current/last grant.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 timeout_err  output  1  sticky; set on DONE_TIMEOUT expiry, cleared only by reset.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT_DONE; encoding free.
REQ-021 IDLE: if any req_valid high, pick winner by round-robin starting at (last_grant+1) mod NUM_REQ; pulse req_ready[winner] for exactly that cycle; latch req_data/req_error of winner and parity_per_byte; update last_grant and grant_id; next state ISSUE.
REQ-022 IDLE with no req_valid: stay, req_ready all zero.
REQ-023 A requester's frame is accepted iff req_valid[k] and req_ready[k] are high in the same cycle; requesters hold data stable only until then.
REQ-024 ISSUE: tx_valid=1, tx_data/tx_error/tx_parity_per_byte driven from latches; hold until a cycle with tx_valid and tx_ready both high; then next state WAIT_DONE.
REQ-025 Latency: accept at cycle N, tx_valid high at N+1.
REQ-026 WAIT_DONE: tx_valid=0; clear timeout counter on entry; increment each cycle; on tx_done go IDLE.
REQ-027 tx_done is sampled only in WAIT_DONE; pulses in IDLE or ISSUE are ignored.
REQ-028 Counter reaching DONE_TIMEOUT-1 without tx_done: set timeout_err, go IDLE.
REQ-029 tx_done and timeout in the same cycle: tx_done wins, timeout_err not set.
REQ-030 Counter width $clog2(DONE_TIMEOUT)+1; no wrap beyond terminal count.
REQ-031 At most one frame outstanding; no new grant while busy; req_ready zero outside IDLE.
REQ-032 Round-robin wraps from NUM_REQ-1 to 0; a requester cannot win twice in a row while another is requesting.
REQ-033 req_valid dropping during ISSUE/WAIT_DONE has no effect on the in-flight frame.

Reset
REQ-034 rst_n low asynchronously forces IDLE; req_ready=0, tx_valid=0, tx_data=0, tx_error=0, tx_parity_per_byte=0, grant_id=0, busy=0, timeout_err=0, counter=0.
REQ-035 last_grant resets to NUM_REQ-1 so requester 0 has first priority.
REQ-036 Reset mid-ISSUE or mid-WAIT_DONE drops the in-flight frame; no retry after release.

Verification
REQ-037 Single request: req_valid[2]=1, data 16'hFCFC -> req_ready=4'b0100 one cycle, tx_valid next cycle with tx_data=16'hFCFC, busy until tx_done.
REQ-038 Contention: all four valid continuously -> grants in order 0,1,2,3,0, each after prior tx_done.
REQ-039 Backpressure: tx_ready low 5 cycles in ISSUE -> tx_valid and tx_data held stable, transition on first ready cycle.
REQ-040 Timeout: DONE_TIMEOUT=16, tx_done never asserted -> timeout_err=1 after 16 WAIT_DONE cycles, FSM IDLE, next request still served.
REQ-041 Stray tx_done in ISSUE ignored; tx_done coincident with timeout -> timeout_err stays 0.
REQ-042 Reset asserted mid-WAIT_DONE -> all outputs zero immediately; after release requester 0 wins first.
